// File: rtl/sensor_density_encoder_if.sv
// Detector-side and controller-side signal bundle for sensor_density_encoder.
// The master modport is the encoder, the slave modport is whoever drives the loops and reads the densities.
interface sensor_density_encoder_if #(
   parameter int CNT_W = 4
);
   logic             det_N;
   logic             det_E;
   logic             dep_N;
   logic             dep_E;
   logic [1:0]       sensor_N;
   logic [1:0]       sensor_E;
   logic [CNT_W-1:0] q_N;
   logic [CNT_W-1:0] q_E;
   logic             fault_N;
   logic             fault_E;

   modport master (
      input  det_N, det_E, dep_N, dep_E,
      output sensor_N, sensor_E, q_N, q_E, fault_N, fault_E
   );

   modport slave (
      output det_N, det_E, dep_N, dep_E,
      input  sensor_N, sensor_E, q_N, q_E, fault_N, fault_E
   );
endinterface

// File: rtl/sensor_density_encoder.sv
// Synchronises and debounces the N/E loop detectors, counts arrivals minus departures and
// encodes each queue as a 2-bit density. Define SENSOR_STUCK_DET_EN to add stuck-high detection.
module sensor_density_encoder #(
   parameter int CNT_W        = 4,
   parameter int DEB_CYCLES   = 3,
   parameter int TH_MID       = 4,
   parameter int TH_HIGH      = 8,
   parameter int STUCK_CYCLES = 1000
) (
   input  logic                     clk,
   input  logic                     reset,
   sensor_density_encoder_if.master bus
);
   localparam int DEB_W = $clog2(DEB_CYCLES + 1);

   logic [1:0]       det;
   logic [1:0]       dep;
   logic [CNT_W-1:0] q_a    [2];
   logic [1:0]       sens_a [2];
   logic [1:0]       flt_a;

   assign det = {bus.det_E, bus.det_N};
   assign dep = {bus.dep_E, bus.dep_N};

   function automatic logic [1:0] encode(input logic [CNT_W-1:0] q);
      if (q == '0)             return 2'd0;
      if (int'(q) < TH_MID)    return 2'd1;
      if (int'(q) < TH_HIGH)   return 2'd2;
      return 2'd3;
   endfunction

   // Index 0 is North, index 1 is East; the two lanes share no state.
   for (genvar i = 0; i < 2; i++) begin : g_lane
      logic             s1;
      logic             s2;
      logic             deb;
      logic             arr;
      logic             settle;
      logic             stuck;
      logic             flt;
      logic [DEB_W-1:0] cnt;
      logic [CNT_W-1:0] q;
      logic [1:0]       sens;

      // The synced level has disagreed with the debounced level long enough to accept it.
      assign settle = (s2 != deb) && (cnt == DEB_W'(DEB_CYCLES - 1));

      always_ff @(posedge clk) begin
         if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            deb  <= 1'b0;
            arr  <= 1'b0;
            cnt  <= '0;
            q    <= '0;
            sens <= 2'd0;
         end else begin
            // NOTE: non-blocking throughout, so every term below reads the pre-edge value.
            s1 <= det[i];
            s2 <= s1;
            if (s2 == deb || settle) cnt <= '0;
            else                     cnt <= cnt + DEB_W'(1);
            if (settle) deb <= ~deb;
            arr <= settle && !deb;
            case ({arr, dep[i]})
               2'b10:   if (q != '1) q <= q + CNT_W'(1);
               2'b01:   if (q != '0) q <= q - CNT_W'(1);
               default: q <= q;
            endcase
            sens <= stuck ? 2'd3 : encode(q);
         end
      end

`ifdef SENSOR_STUCK_DET_EN
      localparam int ST_W = $clog2(STUCK_CYCLES + 1);
      logic [ST_W-1:0] run;

      // Saturated high-time means the loop is stuck; the fail-safe density is 3.
      assign stuck = deb && (run == ST_W'(STUCK_CYCLES));

      always_ff @(posedge clk) begin
         if (!reset) begin
            run <= '0;
            flt <= 1'b0;
         end else begin
            flt <= stuck;
            if (!deb)        run <= '0;
            else if (!stuck) run <= run + ST_W'(1);
         end
      end
`else
      assign stuck = 1'b0;
      assign flt   = 1'b0;
`endif

      assign q_a[i]    = q;
      assign sens_a[i] = sens;
      assign flt_a[i]  = flt;
   end

   assign bus.q_N      = q_a[0];
   assign bus.q_E      = q_a[1];
   assign bus.sensor_N = sens_a[0];
   assign bus.sensor_E = sens_a[1];
   assign bus.fault_N  = flt_a[0];
   assign bus.fault_E  = flt_a[1];
endmodule
